agc_gain_sequencer: RTL and testbench
=====================================

Name: agc_gain_sequencer

Overview:
Closed-loop sequencer for the receiver AGC.
- Measures peak ADC magnitude over a fixed sample window.
- Compares the peak against high and low thresholds and steps a VGA gain code.
- Hands each new code to the gain-DAC/SPI writer through a req/ack handshake, then waits a programmable settling time before measuring again.
- Sits between the ADC sample stream and the gain-writer interface.

Parameters:
- DATA_W, 14, ADC sample width (signed two's complement).
- GAIN_W, 6, gain code width (unsigned; larger = more gain).
- WIN_LOG2, 10, log2 of measurement window length in valid samples.
- SETTLE_W, 12, width of settle-cycle counter.
- FAST_STEP, 4, gain decrement applied on ADC full-scale overload.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, loop enable (level).
- sample_valid, in, 1, sample qualifier.
- sample, in, DATA_W, signed ADC sample.
- thr_hi, in, DATA_W-1, upper peak threshold (unsigned magnitude).
- thr_lo, in, DATA_W-1, lower peak threshold.
- settle_cycles, in, SETTLE_W, post-write hold-off in clk cycles.
- gain_init, in, GAIN_W, code programmed on enable.
- gain_min, in, GAIN_W, lower gain clamp.
- gain_max, in, GAIN_W, upper gain clamp.
- gain_code, out, GAIN_W, current gain code; stable while gain_req=1.
- gain_req, out, 1, write request to gain writer.
- gain_ack, in, 1, writer accepted code (1-cycle pulse or level).
- peak, out, DATA_W-1, last completed window peak.
- peak_valid, out, 1, 1-cycle pulse when peak updates.
- locked, out, 1, last decision made no gain change.
- busy, out, 1, high in any state except IDLE.

Behaviour:
- Reset (async): state=IDLE; gain_code=0, gain_req=0, peak=0, peak_valid=0, locked=0, busy=0; internal counters cleared.
- IDLE -> WRITE when enable=1. On that transition gain_code <= gain_init clamped to [gain_min, gain_max].
- WRITE:
  - gain_req=1 from the first WRITE cycle.
  - The first cycle with gain_ack=1 ends the handshake: gain_req is 0 on the next cycle.
  - Next state is SETTLE, with the counter loaded from settle_cycles.
  - gain_ack while not in WRITE is ignored.
- SETTLE: decrements each cycle; exits to MEASURE in the cycle the counter is 0. settle_cycles=0 means exactly one SETTLE cycle.
- MEASURE:
  - On entry, clear the window peak and sample count.
  - Per valid sample: mag = |sample|; the most negative value saturates to 2^(DATA_W-1)-1. Window peak = max(peak, mag).
  - Samples with sample_valid=0 are not counted.
  - After 2^WIN_LOG2 valid samples -> DECIDE. The last sample is included in the peak.
  - Samples arriving during WRITE/SETTLE/DECIDE are discarded.
- DECIDE (one cycle): peak <= window peak; peak_valid=1. Decision, first match wins:
  - (a) Window peak = full scale (2^(DATA_W-1)-1): gain_code <= max(gain_code-FAST_STEP, gain_min), saturating with no underflow; -> WRITE if changed.
  - (b) Peak > thr_hi and gain_code > gain_min: gain_code-1 -> WRITE.
  - (c) Peak < thr_lo and gain_code < gain_max: gain_code+1 -> WRITE.
  - (d) Otherwise: no change -> MEASURE (new window) and locked=1.
  - Any change clears locked.
  - If thr_lo >= thr_hi, the high test has priority (as ordered).
  - A clamp hit (e.g. overload at gain_min) behaves as (d) but leaves locked=0.
- enable deassert:
  - In SETTLE/MEASURE/DECIDE: -> IDLE next cycle. The window is discarded and no peak_valid pulse is issued.
  - In WRITE: the handshake completes (req held until ack), then -> IDLE.
  - gain_code and peak hold their values in IDLE.
- Threshold and clamp inputs are sampled live; they are only required stable in DECIDE.
- Latency: the last valid sample to peak_valid is 2 cycles (count register, then DECIDE).

Decomposition:
- agc_pkg holds:
  - state encoding (IDLE, WRITE, SETTLE, MEASURE, DECIDE);
  - FULL_SCALE constant as a function of DATA_W;
  - the step constants.
- Natural sub-module: agc_peak_detector. It contains the magnitude/saturation logic, running max, window counter, window_done output and a clear input. The FSM and gain arithmetic stay in the top level.

Test Plan:
- Enable with gain_init=20, gain_ack 3 cycles after req, settle_cycles=5 -> gain_req high exactly until ack; MEASURE starts 6 cycles after ack.
- Window of constant sample=+3000, thr_hi=2500, thr_lo=1000, gain=20 -> peak_valid with peak=3000; gain_code=19; gain_req asserted the next cycle.
- Window containing one sample of -8192 (DATA_W=14), gain=6, gain_min=4 -> peak=8191; gain_code=4 (clamped); one write.
- Window peak 500 with gain=gain_max=63 -> no write; locked=0; a new MEASURE starts immediately. Peak 1500 (in band) -> locked=1.
- enable dropped mid-MEASURE -> IDLE next cycle, no peak_valid. enable dropped in WRITE before ack -> req held until ack, then IDLE; busy=0.
- rst asserted mid-WRITE -> all outputs zero asynchronously; re-enable -> gain_init rewritten.

Source files
------------

// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared state encoding and step constants for the AGC gain sequencer
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE
  } agc_state_t;

  localparam int SLOW_STEP         = 1;
  localparam int FAST_STEP_DEFAULT = 4;

  // Largest positive magnitude representable by a signed sample of data_w bits.
  function automatic int unsigned full_scale(input int unsigned data_w);
    return (32'd1 << (data_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/agc_peak_detector.sv
// rtl/agc_peak_detector.sv - windowed peak magnitude of a signed sample stream
module agc_peak_detector
  import agc_pkg::*;
#(
  parameter int DATA_W   = 14,
  parameter int WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accept,
  input  logic signed [DATA_W-1:0] sample,
  output logic        [DATA_W-2:0] peak,
  output logic                     window_done
);

  localparam logic [DATA_W-2:0] FS = (DATA_W-1)'(full_scale(DATA_W));
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [WIN_LOG2:0] count;
  logic [DATA_W-2:0] mag;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    if (sample == MOST_NEG) mag = FS;
    else if (sample[DATA_W-1]) mag = (DATA_W-1)'(-sample);
    else mag = sample[DATA_W-2:0];
  end

  assign window_done = count[WIN_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      peak  <= '0;
    end else if (clear) begin
      count <= '0;
      peak  <= '0;
    end else if (accept && !window_done) begin
      count <= count + (WIN_LOG2+1)'(1);
      if (mag > peak) peak <= mag;
    end
  end

endmodule

// File: rtl/agc_gain_sequencer.sv
// rtl/agc_gain_sequencer.sv - closed-loop AGC: measure window peak, step gain, write, settle
module agc_gain_sequencer
  import agc_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int GAIN_W    = 6,
  parameter int WIN_LOG2  = 10,
  parameter int SETTLE_W  = 12,
  parameter int FAST_STEP = FAST_STEP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [DATA_W-2:0] thr_hi,
  input  logic        [DATA_W-2:0] thr_lo,
  input  logic      [SETTLE_W-1:0] settle_cycles,
  input  logic        [GAIN_W-1:0] gain_init,
  input  logic        [GAIN_W-1:0] gain_min,
  input  logic        [GAIN_W-1:0] gain_max,
  output logic        [GAIN_W-1:0] gain_code,
  output logic                     gain_req,
  input  logic                     gain_ack,
  output logic        [DATA_W-2:0] peak,
  output logic                     peak_valid,
  output logic                     locked,
  output logic                     busy
);

  localparam logic [DATA_W-2:0] FS   = (DATA_W-1)'(full_scale(DATA_W));
  localparam logic [GAIN_W:0]   FAST = (GAIN_W+1)'(FAST_STEP);

  agc_state_t          state, next_state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DATA_W-2:0]   peak_q;
  logic [DATA_W-2:0]   win_peak;
  logic                window_done;
  logic                clear_win;
  logic [GAIN_W-1:0]   init_clamped;
  logic [GAIN_W-1:0]   gain_next;
  logic                in_band;

  agc_peak_detector #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) u_peak (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_win),
    .accept      (state == ST_MEASURE && sample_valid),
    .sample      (sample),
    .peak        (win_peak),
    .window_done (window_done)
  );

  always_comb begin
    init_clamped = gain_init;
    if (gain_init < gain_min) init_clamped = gain_min;
    else if (gain_init > gain_max) init_clamped = gain_max;
  end

  // A clamp hit leaves gain unchanged without counting as in-band, so locked stays low.
  always_comb begin
    gain_next = gain_code;
    in_band   = 1'b0;
    if (win_peak == FS) begin
      if ({1'b0, gain_code} >= ({1'b0, gain_min} + FAST)) gain_next = gain_code - FAST[GAIN_W-1:0];
      else gain_next = gain_min;
    end else if (win_peak > thr_hi) begin
      if (gain_code > gain_min) gain_next = gain_code - GAIN_W'(SLOW_STEP);
    end else if (win_peak < thr_lo) begin
      if (gain_code < gain_max) gain_next = gain_code + GAIN_W'(SLOW_STEP);
    end else begin
      in_band = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (enable) next_state = ST_WRITE;
      ST_WRITE:   if (gain_ack) next_state = enable ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:  if (!enable) next_state = ST_IDLE;
                  else if (settle_cnt == '0) next_state = ST_MEASURE;
      ST_MEASURE: if (!enable) next_state = ST_IDLE;
                  else if (window_done) next_state = ST_DECIDE;
      ST_DECIDE:  if (!enable) next_state = ST_IDLE;
                  else if (gain_next != gain_code) next_state = ST_WRITE;
                  else next_state = ST_MEASURE;
      default:    next_state = ST_IDLE;
    endcase
  end

  assign clear_win = (next_state == ST_MEASURE) && (state != ST_MEASURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gain_code  <= '0;
      settle_cnt <= '0;
      peak_q     <= '0;
      locked     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: if (enable) begin
          gain_code <= init_clamped;
          locked    <= 1'b0;
        end
        ST_WRITE:  if (gain_ack) settle_cnt <= settle_cycles;
        ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
        ST_DECIDE: if (enable) begin
          peak_q    <= win_peak;
          gain_code <= gain_next;
          locked    <= in_band;
        end
        default: ;
      endcase
    end
  end

  // The fresh window peak is shown directly during its valid pulse.
  assign peak_valid = (state == ST_DECIDE) && enable;
  assign peak       = peak_valid ? win_peak : peak_q;
  assign gain_req   = (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// tb/tb_agc_gain_sequencer.sv - randomized self-checking bench for agc_gain_sequencer
module tb_agc_gain_sequencer;

  localparam int DATA_W = 14, GAIN_W = 6, WIN_LOG2 = 4, SETTLE_W = 12, FAST_STEP = 4;
  localparam int WIN = 1 << WIN_LOG2;
  localparam int FS  = 8191;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic                     sample_valid = 1'b0;
  logic signed [DATA_W-1:0] sample = '0;
  logic        [DATA_W-2:0] thr_hi = '0, thr_lo = '0;
  logic      [SETTLE_W-1:0] settle_cycles = '0;
  logic        [GAIN_W-1:0] gain_init = '0, gain_min = '0, gain_max = '1;
  logic                     gain_ack = 1'b0;
  logic        [GAIN_W-1:0] gain_code;
  logic                     gain_req, peak_valid, locked, busy;
  logic        [DATA_W-2:0] peak;

  int checks = 0, errors = 0;
  int g_model = 0;
  int last_wp = 0;

  agc_gain_sequencer #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .WIN_LOG2(WIN_LOG2),
                       .SETTLE_W(SETTLE_W), .FAST_STEP(FAST_STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid), .sample(sample),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .settle_cycles(settle_cycles), .gain_init(gain_init),
    .gain_min(gain_min), .gain_max(gain_max), .gain_code(gain_code), .gain_req(gain_req),
    .gain_ack(gain_ack), .peak(peak), .peak_valid(peak_valid), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic int mag(input int v);
    if (v == -8192) return FS;
    return (v < 0) ? -v : v;
  endfunction

  // Samples offered while the loop must not be measuring are full-scale, so any leak shows in the peak.
  task automatic poison();
    sample_valid = 1'b1;
    sample = 14'(-8192);
  endtask

  task automatic measure_window(input int pre, input int kind, input int amp, output int wp);
    int vals[$];
    int idx, v, gap;
    idx = $urandom_range(0, WIN - 1);
    for (int i = 0; i < WIN; i++) begin
      if (kind == 0) v = amp;
      else v = $urandom_range(0, 2 * amp) - amp;
      if (i == idx) v = (kind == 2) ? -8192 : (($urandom % 2) ? amp : -amp);
      vals.push_back(v);
    end
    wp = 0;
    foreach (vals[i]) if (mag(vals[i]) > wp) wp = mag(vals[i]);
    for (int c = 0; c < pre; c++) begin
      poison();
      gain_ack = 1'($urandom % 2);
      #2;
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL settle_pv got %0d want 0", peak_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL settle_busy got %0d want 1", busy); end
      nxt();
    end
    foreach (vals[i]) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        sample_valid = 1'b0;
        sample = 14'(-8192);
        gain_ack = 1'($urandom % 2);
        #2;
        checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL gap_pv got %0d want 0", peak_valid); end
        nxt();
      end
      sample_valid = 1'b1;
      sample = 14'(vals[i]);
      gain_ack = 1'($urandom % 2);
      #2;
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL meas_pv got %0d want 0", peak_valid); end
      checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL meas_req got %0d want 0", gain_req); end
      nxt();
    end
    poison();
    #2;
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL pv_early got %0d want 0", peak_valid); end
    nxt();
    #2;
    checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL pv_latency got %0d want 1", peak_valid); end
    checks++; if (peak !== 13'(wp)) begin errors++; $display("FAIL window_peak got %0d want %0d", peak, wp); end
    nxt();
    sample_valid = 1'b0;
    gain_ack = 1'b0;
  endtask

  task automatic decide_check(input int wp, output bit changed);
    int ng;
    bit lk;
    ng = g_model;
    if (wp == FS) begin
      ng = g_model - FAST_STEP;
      if (ng < int'(gain_min)) ng = int'(gain_min);
    end else if (wp > int'(thr_hi)) begin
      if (g_model > int'(gain_min)) ng = g_model - 1;
    end else if (wp < int'(thr_lo)) begin
      if (g_model < int'(gain_max)) ng = g_model + 1;
    end
    lk = !(wp == FS || wp > int'(thr_hi) || wp < int'(thr_lo));
    changed = (ng != g_model);
    g_model = ng;
    #2;
    checks++; if (gain_req !== changed) begin errors++; $display("FAIL decide_req got %0d want %0d", gain_req, changed); end
    checks++; if (gain_code !== 6'(ng)) begin errors++; $display("FAIL decide_code got %0d want %0d", gain_code, ng); end
    checks++; if (locked !== lk) begin errors++; $display("FAIL decide_locked got %0d want %0d", locked, lk); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL decide_busy got %0d want 1", busy); end
  endtask

  task automatic write_phase(input int exp_code, input int ack_delay, input bit drop);
    gain_ack = 1'b0;
    poison();
    for (int k = 0; k < ack_delay; k++) begin
      if (drop && k == 0) enable = 1'b0;
      #2;
      checks++; if (gain_req !== 1'b1) begin errors++; $display("FAIL req_hold got %0d want 1", gain_req); end
      checks++; if (gain_code !== 6'(exp_code)) begin errors++; $display("FAIL write_code got %0d want %0d", gain_code, exp_code); end
      nxt();
    end
    gain_ack = 1'b1;
    #2;
    checks++; if (gain_req !== 1'b1) begin errors++; $display("FAIL req_at_ack got %0d want 1", gain_req); end
    checks++; if (gain_code !== 6'(exp_code)) begin errors++; $display("FAIL ack_code got %0d want %0d", gain_code, exp_code); end
    nxt();
    gain_ack = 1'b0;
    #2;
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL req_after_ack got %0d want 0", gain_req); end
    checks++; if (busy !== !drop) begin errors++; $display("FAIL busy_after_ack got %0d want %0d", busy, !drop); end
  endtask

  task automatic test_reset();
    repeat (2) nxt();
    checks++; if (gain_code !== '0) begin errors++; $display("FAIL rst_code got %0d want 0", gain_code); end
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0d want 0", gain_req); end
    checks++; if (peak !== '0) begin errors++; $display("FAIL rst_peak got %0d want 0", peak); end
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL rst_pv got %0d want 0", peak_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0d want 0", locked); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
    rst = 1'b0;
    nxt();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0d want 0", busy); end
  endtask

  task automatic test_enable_write();
    thr_hi = 13'd2500; thr_lo = 13'd1000; settle_cycles = 12'd5;
    gain_min = 6'd0; gain_max = 6'd63; gain_init = 6'd20;
    enable = 1'b1;
    #2;
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0d want 0", gain_req); end
    nxt();
    g_model = 20;
    write_phase(20, 3, 1'b0);
  endtask

  task automatic test_overshoot();
    bit ch;
    measure_window(6, 0, 3000, last_wp);
    decide_check(last_wp, ch);
    if (ch) write_phase(g_model, 2, 1'b0);
  endtask

  task automatic test_disable_settle();
    enable = 1'b0;
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL settle_busy got %0d want 1", busy); end
    nxt();
    gain_ack = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got %0d want 0", busy); end
    checks++; if (gain_code !== 6'(g_model)) begin errors++; $display("FAIL dis_code got %0d want %0d", gain_code, g_model); end
    checks++; if (peak !== 13'd3000) begin errors++; $display("FAIL dis_peak got %0d want 3000", peak); end
    nxt();
    gain_ack = 1'b0;
    #2;
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL idle_ack_req got %0d want 0", gain_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ack_busy got %0d want 0", busy); end
    nxt();
  endtask

  task automatic test_overload();
    bit ch;
    gain_min = 6'd4; gain_init = 6'd6; settle_cycles = 12'd1;
    enable = 1'b1;
    nxt();
    g_model = 6;
    write_phase(6, 1, 1'b0);
    measure_window(2, 2, 2000, last_wp);
    decide_check(last_wp, ch);
    checks++; if (gain_code !== 6'd4) begin errors++; $display("FAIL overload_clamp got %0d want 4", gain_code); end
    write_phase(4, 2, 1'b1);
    nxt();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_write_busy got %0d want 0", busy); end
    checks++; if (peak !== 13'd8191) begin errors++; $display("FAIL overload_peak got %0d want 8191", peak); end
    nxt();
  endtask

  task automatic test_clamp_lock();
    bit ch;
    gain_max = 6'd63; gain_init = 6'd63; settle_cycles = 12'd0;
    enable = 1'b1;
    nxt();
    g_model = 63;
    write_phase(63, 0, 1'b0);
    measure_window(1, 1, 500, last_wp);
    decide_check(last_wp, ch);
    measure_window(0, 1, 1500, last_wp);
    decide_check(last_wp, ch);
  endtask

  task automatic test_abort_measure();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample = 14'($urandom_range(0, 400));
      nxt();
    end
    enable = 1'b0;
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %0d want 1", busy); end
    nxt();
    for (int i = 0; i < 2 * WIN; i++) begin
      sample_valid = 1'b1;
      sample = 14'($urandom_range(0, 8000));
      #2;
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL abort_pv got %0d want 0", peak_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0d want 0", busy); end
      checks++; if (peak !== 13'(last_wp)) begin errors++; $display("FAIL abort_peak got %0d want %0d", peak, last_wp); end
      nxt();
    end
  endtask

  task automatic test_reset_mid_write(output int pre);
    gain_init = 6'd33; settle_cycles = 12'd2;
    enable = 1'b1;
    nxt();
    #2;
    checks++; if (gain_req !== 1'b1) begin errors++; $display("FAIL pre_rst_req got %0d want 1", gain_req); end
    rst = 1'b1;
    #1;
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL async_req got %0d want 0", gain_req); end
    checks++; if (gain_code !== '0) begin errors++; $display("FAIL async_code got %0d want 0", gain_code); end
    checks++; if (peak !== '0) begin errors++; $display("FAIL async_peak got %0d want 0", peak); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %0d want 0", locked); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %0d want 0", busy); end
    repeat (2) nxt();
    rst = 1'b0;
    #2;
    checks++; if (gain_req !== 1'b0) begin errors++; $display("FAIL rel_req got %0d want 0", gain_req); end
    nxt();
    g_model = 33;
    write_phase(33, 1, 1'b0);
    pre = 3;
  endtask

  task automatic test_random(input int n, input int pre_in);
    int pre, amp, kind, s;
    bit ch;
    pre = pre_in;
    for (int it = 0; it < n; it++) begin
      thr_hi = 13'($urandom_range(1500, 6000));
      thr_lo = 13'($urandom_range(0, 7000));
      amp = $urandom_range(0, 8191);
      kind = ($urandom_range(0, 7) == 0) ? 2 : 1;
      measure_window(pre, kind, amp, last_wp);
      decide_check(last_wp, ch);
      if (ch) begin
        s = $urandom_range(0, 3);
        settle_cycles = 12'(s);
        write_phase(g_model, $urandom_range(0, 3), 1'b0);
        pre = s + 1;
      end else begin
        pre = 0;
      end
    end
  endtask

  initial begin
    int pre;
    test_reset();
    test_enable_write();
    test_overshoot();
    test_disable_settle();
    test_overload();
    test_clamp_lock();
    test_abort_measure();
    test_reset_mid_write(pre);
    test_random(25, pre);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
